// File: rtl/in_channel_pkg.sv
// in_channel_feeder shared types: channel word, feeder state.
// Optional peek port is enabled by defining IN_CHANNEL_PEEK_EN.
package in_channel_pkg;

  localparam int unsigned WordWidth = 12;

  typedef enum logic [1:0] {
    OPEN    = 2'd0,
    CLOSED  = 2'd1,
    DRAINED = 2'd2
  } feeder_state_t;

  typedef logic [WordWidth-1:0] channel_word_t;

endpackage

// File: rtl/in_channel_ram.sv
// Simple dual-port register array: synchronous write, registered read.
// Contents are never reset.
module in_channel_ram
  import in_channel_pkg::*;
#(
  parameter int Width = int'(WordWidth),
  parameter int Depth = 8,
  localparam int AW = $clog2(Depth)
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [Width-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [Width-1:0] rd_data
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/in_channel_feeder.sv
// Producer side of the interpreter input channel: host FIFO, pop/underflow.
// Define IN_CHANNEL_PEEK_EN to add the non-popping peek port.
module in_channel_feeder
  import in_channel_pkg::*;
#(
  parameter int MemoryElementWidth = int'(WordWidth),
  parameter int NIn = 8,
  parameter int PosWidth = 12,
  localparam int CW = $clog2(NIn + 1),
  localparam int AW = $clog2(NIn)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          hostValid,
  input  logic                          hostLast,
  input  logic [MemoryElementWidth-1:0] hostData,
  output logic                          hostReady,
  input  logic                          readReq,
  output logic                          readValid,
  output logic [MemoryElementWidth-1:0] readData,
`ifdef IN_CHANNEL_PEEK_EN
  input  logic                          peekReq,
  output logic                          peekValid,
  output logic [MemoryElementWidth-1:0] peekData,
`endif
  output logic [CW-1:0]                 count,
  output logic                          empty,
  output logic                          exhausted,
  output logic                          underflow,
  output logic [PosWidth-1:0]           readPos
);

  localparam logic [CW-1:0] Full    = CW'(NIn);
  localparam logic [AW-1:0] LastPtr = AW'(NIn - 1);

  feeder_state_t state, state_n;

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_n;
  logic          push, pop, under;
  logic          rd_en;
  logic          read_sel;
  logic [MemoryElementWidth-1:0] ram_q;

`ifdef IN_CHANNEL_PEEK_EN
  logic peek_go;
  logic peek_sel;
`endif

  assign hostReady = (state == OPEN) && (count < Full);
  assign empty     = (count == '0);
  assign exhausted = (state == DRAINED);

  assign push  = hostValid && hostReady;
  assign pop   = readReq && !empty;
  assign under = readReq && empty;

`ifdef IN_CHANNEL_PEEK_EN
  // A pop in the same cycle wins over the peek.
  assign peek_go = peekReq && !readReq;
  assign rd_en   = pop || (peek_go && !empty);
`else
  assign rd_en   = pop;
`endif

  always_comb begin
    count_n = count;
    state_n = state;
    case ({push, pop})
      2'b10:   count_n = count + CW'(1);
      2'b01:   count_n = count - CW'(1);
      default: count_n = count;
    endcase
    unique case (state)
      OPEN: begin
        if (push && hostLast) begin
          state_n = (count_n == '0) ? DRAINED : CLOSED;
        end
      end
      CLOSED: begin
        if (count_n == '0) begin
          state_n = DRAINED;
        end
      end
      DRAINED: state_n = DRAINED;
      default: state_n = OPEN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= OPEN;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      readPos   <= '0;
      underflow <= 1'b0;
      readValid <= 1'b0;
      read_sel  <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      readValid <= readReq;
      if (push) begin
        wr_ptr <= (wr_ptr == LastPtr) ? '0 : wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr   <= (rd_ptr == LastPtr) ? '0 : rd_ptr + AW'(1);
        readPos  <= readPos + PosWidth'(1);
        read_sel <= 1'b1;
      end else if (under) begin
        read_sel <= 1'b0;
      end
      if (under) begin
        underflow <= 1'b1;
      end
    end
  end

  // Underflow reads show 0, the interpreter's read-past-end value.
  assign readData = read_sel ? ram_q : '0;

`ifdef IN_CHANNEL_PEEK_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      peekValid <= 1'b0;
      peek_sel  <= 1'b0;
    end else begin
      peekValid <= peek_go;
      if (peek_go) begin
        peek_sel <= !empty;
      end
    end
  end

  assign peekData = peek_sel ? ram_q : '0;
`endif

  in_channel_ram #(
    .Width (MemoryElementWidth),
    .Depth (NIn)
  ) u_ram (
    .clock   (clock),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (hostData),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr),
    .rd_data (ram_q)
  );

endmodule
